// File: rtl/tlv493_pkg.sv
// Shared types and constants for the TLV493D I2C target emulation.
package tlv493_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic [6:0] TLV493_DEFAULT_ADDR = 7'h5E;

  localparam logic [3:0] REG_BX_HI    = 4'd0;
  localparam logic [3:0] REG_BY_HI    = 4'd1;
  localparam logic [3:0] REG_BZ_HI    = 4'd2;
  localparam logic [3:0] REG_TEMP_HI  = 4'd3;
  localparam logic [3:0] REG_BXY_LO   = 4'd4;
  localparam logic [3:0] REG_BZ_LO    = 4'd5;
  localparam logic [3:0] REG_TEMP_LO  = 4'd6;
  localparam logic [3:0] REG_FACTORY7 = 4'd7;
  localparam logic [3:0] REG_FACTORY8 = 4'd8;
  localparam logic [3:0] REG_FACTORY9 = 4'd9;

  localparam logic [3:0] READ_MAP_LEN  = 4'd10;
  localparam logic [2:0] WRITE_MAP_LEN = 3'd4;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes and deglitches SCL/SDA, then derives SCL edges and START/STOP
// from the filtered levels. Input-to-level latency is 2+FILTER_DEPTH cycles.
module i2c_line_filter #(
  parameter int FILTER_DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  localparam logic [2:0] CNT_LAST = 3'(FILTER_DEPTH - 1);

  logic [1:0] scl_sync, sda_sync;
  logic [2:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_p, sda_p;

  // Idle bus is high on both lines, so reset to 1 to avoid a fake START.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_p    <= scl_f;
      sda_p    <= sda_f;

      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_LAST) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 3'd1;
      end

      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_LAST) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 3'd1;
      end
    end
  end

  assign sda      = sda_f;
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  // SCL must be high in both cycles so a simultaneous SCL change is not a bus condition.
  assign start    = scl_f & scl_p & ~sda_f & sda_p;
  assign stop     = scl_f & scl_p & sda_f & ~sda_p;

endmodule

// File: rtl/tlv493_i2c_responder.sv
// I2C target emulating a TLV493D: serves the 10-byte read map from a coherent
// snapshot of fabric values and stores the 4-byte config write map.
//
// state    | meaning
// IDLE     | bus free or not addressed
// ADDR     | shifting in address + R/W
// ADDR_ACK | driving ACK for the address byte
// WR_DATA  | shifting in a config byte
// WR_ACK   | driving ACK for a written byte
// RD_DATA  | shifting out a read-map byte
// RD_ACK   | released, sampling master ACK/NACK
// IGNORE   | not ours or read ended; wait for START/STOP
module tlv493_i2c_responder
  import tlv493_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS  = TLV493_DEFAULT_ADDR,
  parameter int         FILTER_DEPTH = 3,
  parameter logic [7:0] FACTORY7     = 8'h00,
  parameter logic [7:0] FACTORY8     = 8'h00,
  parameter logic [7:0] FACTORY9     = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] mag_x,
  input  logic [11:0] mag_y,
  input  logic [11:0] mag_z,
  input  logic [11:0] temp,
  input  logic        sample_valid,
  output logic [31:0] cfg_regs,
  output logic        cfg_write,
  output logic        busy
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_line_filter (
    .clock    (clock),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [6:0]  tx;
  logic        rw;
  logic [3:0]  ptr;
  logic [2:0]  wr_idx;
  logic        wr_stored;
  logic [7:0]  rd_byte;

  logic [11:0] snap_x, snap_y, snap_z, snap_t;
  logic [11:0] pend_x, pend_y, pend_z, pend_t;
  logic        pend_valid;
  logic [1:0]  frm;
  logic        rd_active, rd_end;

  assign rd_active = (state == RD_DATA) || (state == RD_ACK);
  assign rd_end    = rd_active && (start || stop || (state == RD_ACK && scl_rise && sda));

  always_comb begin
    rd_byte = 8'h00;
    case (ptr)
      REG_BX_HI:    rd_byte = snap_x[11:4];
      REG_BY_HI:    rd_byte = snap_y[11:4];
      REG_BZ_HI:    rd_byte = snap_z[11:4];
      REG_TEMP_HI:  rd_byte = {snap_t[11:8], frm, 2'b00};
      REG_BXY_LO:   rd_byte = {snap_x[3:0], snap_y[3:0]};
      REG_BZ_LO:    rd_byte = {3'b000, 1'b1, snap_z[3:0]};
      REG_TEMP_LO:  rd_byte = snap_t[7:0];
      REG_FACTORY7: rd_byte = FACTORY7;
      REG_FACTORY8: rd_byte = FACTORY8;
      REG_FACTORY9: rd_byte = FACTORY9;
      default:      rd_byte = 8'h00;
    endcase
  end

  // Strobes during a read are parked so every byte of one read comes from one sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_x     <= '0;
      snap_y     <= '0;
      snap_z     <= '0;
      snap_t     <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_z     <= '0;
      pend_t     <= '0;
      pend_valid <= 1'b0;
      frm        <= '0;
    end else if (rd_end) begin
      pend_valid <= 1'b0;
      if (sample_valid) begin
        {snap_x, snap_y, snap_z, snap_t} <= {mag_x, mag_y, mag_z, temp};
        frm <= frm + 2'd1;
      end else if (pend_valid) begin
        {snap_x, snap_y, snap_z, snap_t} <= {pend_x, pend_y, pend_z, pend_t};
        frm <= frm + 2'd1;
      end
    end else if (sample_valid) begin
      if (rd_active) begin
        {pend_x, pend_y, pend_z, pend_t} <= {mag_x, mag_y, mag_z, temp};
        pend_valid <= 1'b1;
      end else begin
        {snap_x, snap_y, snap_z, snap_t} <= {mag_x, mag_y, mag_z, temp};
        frm <= frm + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      rw        <= 1'b0;
      ptr       <= '0;
      wr_idx    <= '0;
      wr_stored <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      cfg_write <= 1'b0;
      cfg_regs  <= '0;
    end else begin
      cfg_write <= 1'b0;
      if (start || stop) begin
        cfg_write <= wr_stored;
        wr_stored <= 1'b0;
        sda_oe    <= 1'b0;
        bit_cnt   <= '0;
        ptr       <= '0;
        if (stop) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state <= ADDR;
        end
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg <= {shreg[5:0], sda};
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (shreg == I2C_ADDRESS) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
                rw    <= sda;
              end else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          // First falling edge starts the ACK, the second ends the 9th clock.
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else if (rw) begin
              state   <= RD_DATA;
              tx      <= rd_byte[6:0];
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= '0;
            end else begin
              state   <= WR_DATA;
              sda_oe  <= 1'b0;
              wr_idx  <= '0;
              bit_cnt <= '0;
            end
          end

          WR_DATA: if (scl_rise) begin
            shreg <= {shreg[5:0], sda};
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              state   <= WR_ACK;
              if (wr_idx < WRITE_MAP_LEN) begin
                case (wr_idx[1:0])
                  2'd0:    cfg_regs[31:24] <= {shreg, sda};
                  2'd1:    cfg_regs[23:16] <= {shreg, sda};
                  2'd2:    cfg_regs[15:8]  <= {shreg, sda};
                  default: cfg_regs[7:0]   <= {shreg, sda};
                endcase
                wr_idx    <= wr_idx + 3'd1;
                wr_stored <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          WR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end
          end

          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
                if (ptr != READ_MAP_LEN) ptr <= ptr + 4'd1;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[5:0], 1'b0};
              end
            end
          end

          // bit_cnt==9 marks an ACK seen on the 9th rising edge.
          RD_ACK: begin
            if (scl_rise) begin
              if (sda) state <= IGNORE;
              else     bit_cnt <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              state   <= RD_DATA;
              tx      <= rd_byte[6:0];
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= '0;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tlv493_i2c_responder.sv
// Bench for tlv493_i2c_responder: bit-banged I2C master, table of snapshot
// vectors, and a queue of expected read bytes checked as each byte arrives.
module tb_tlv493_i2c_responder;

  localparam int         Q    = 8;
  localparam int         FD   = 3;
  localparam logic [6:0] ADDR = 7'h5E;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda_low = 1'b0;
  logic        sda_bus;
  logic        sda_oe, cfg_write, busy;
  logic        sample_valid = 1'b0;
  logic [11:0] mag_x = '0, mag_y = '0, mag_z = '0, temp = '0;
  logic [31:0] cfg_regs;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulse_cnt = 0;
  int   bad_line_cnt = 0;
  logic watch = 1'b0;
  logic [7:0] exp_q [$];

  typedef struct packed {
    logic [11:0] x, y, z, t;
    logic [79:0] exp;
  } vec_t;
  vec_t vecs [3];

  always #5 clock = ~clock;
  assign sda_bus = ~(sda_oe | m_sda_low);

  tlv493_i2c_responder #(
    .I2C_ADDRESS (ADDR),
    .FILTER_DEPTH(FD),
    .FACTORY7    (8'h11),
    .FACTORY8    (8'h22),
    .FACTORY9    (8'h33)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .scl_in      (m_scl),
    .sda_in      (sda_bus),
    .sda_oe      (sda_oe),
    .mag_x       (mag_x),
    .mag_y       (mag_y),
    .mag_z       (mag_z),
    .temp        (temp),
    .sample_valid(sample_valid),
    .cfg_regs    (cfg_regs),
    .cfg_write   (cfg_write),
    .busy        (busy)
  );

  always @(negedge clock) begin
    if (cfg_write) pulse_cnt = pulse_cnt + 1;
    if (watch && (sda_oe || busy)) bad_line_cnt = bad_line_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; cyc(Q);
    m_scl = 1'b1;     cyc(Q);
    m_sda_low = 1'b1; cyc(Q);
    m_scl = 1'b0;     cyc(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; cyc(Q);
    m_scl = 1'b1;     cyc(Q);
    m_sda_low = 1'b0; cyc(2 * Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    m_sda_low = ~b;
    if (glitch) begin
      cyc(2); m_scl = 1'b1; cyc(FD - 1); m_scl = 1'b0; cyc(Q - 2 - (FD - 1));
    end else begin
      cyc(Q);
    end
    m_scl = 1'b1; cyc(2 * Q);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; cyc(Q);
    b = sda_bus;
    m_scl = 1'b1; cyc(2 * Q);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch && (i == 4));
    recv_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack, 1'b0);
  endtask

  task automatic strobe(input logic [11:0] x, y, z, t);
    mag_x = x; mag_y = y; mag_z = z; temp = t;
    sample_valid = 1'b1; cyc(1);
    sample_valid = 1'b0; cyc(1);
  endtask

  task automatic push10(input logic [79:0] e);
    for (int k = 0; k < 10; k++) exp_q.push_back(e[79 - 8 * k -: 8]);
  endtask

  // Reads n bytes (last one NACKed) and checks each against the queue head.
  task automatic read_txn(input int n, input int strobe_after);
    logic       ack;
    logic [7:0] b;
    i2c_start();
    write_byte({ADDR, 1'b1}, 1'b0, ack);
    check("read_addr_ack", 32'(ack), 32'd1);
    check("busy_in_read", 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      read_byte(b, k != n - 1);
      check($sformatf("read_byte_%0d", k), 32'(b), 32'(exp_q.pop_front()));
      if (k == strobe_after) begin
        strobe(12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC);
        strobe(12'h135, 12'h246, 12'h9AB, 12'hCDE);
      end
    end
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;
    logic       bit_v;
    int         base;
    logic [7:0] wdata [4];

    vecs[0] = '{12'hABC, 12'h123, 12'h456, 12'h789,
               {8'hAB, 8'h12, 8'h45, 8'h74, 8'hC3, 8'h16, 8'h89, 8'h11, 8'h22, 8'h33}};
    vecs[1] = '{12'h800, 12'hFFF, 12'h07F, 12'h001,
               {8'h80, 8'hFF, 8'h07, 8'h08, 8'h0F, 8'h1F, 8'h01, 8'h11, 8'h22, 8'h33}};
    vecs[2] = '{12'h5A5, 12'hA5A, 12'h3C3, 12'hFEF,
               {8'h5A, 8'hA5, 8'h3C, 8'hFC, 8'h5A, 8'h13, 8'hEF, 8'h11, 8'h22, 8'h33}};
    wdata = '{8'h00, 8'h05, 8'h00, 8'h40};

    cyc(3);
    check("reset_sda_oe", 32'(sda_oe), 32'd0);
    check("reset_cfg_regs", cfg_regs, 32'd0);
    check("reset_cfg_write", 32'(cfg_write), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cyc(4);

    // Snapshot then read: p10/p11 past the map read as zero.
    for (int i = 0; i < 3; i++) begin
      strobe(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].t);
      push10(vecs[i].exp);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      read_txn(12, -1);
    end

    // Wrong address: no ACK, line and busy stay quiet.
    base  = bad_line_cnt;
    watch = 1'b1;
    i2c_start();
    write_byte({7'h5F, 1'b1}, 1'b0, ack);
    check("wrong_addr_nack", 32'(ack), 32'd0);
    read_byte(b, 1'b0);
    check("wrong_addr_bus", 32'(b), 32'hFF);
    i2c_stop();
    watch = 1'b0;
    check("wrong_addr_quiet", 32'(bad_line_cnt - base), 32'd0);

    // Address-only write stores nothing.
    base = pulse_cnt;
    i2c_start();
    write_byte({ADDR, 1'b0}, 1'b0, ack);
    check("empty_write_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("empty_write_no_pulse", 32'(pulse_cnt - base), 32'd0);

    // Config write of four bytes.
    base = pulse_cnt;
    i2c_start();
    write_byte({ADDR, 1'b0}, 1'b0, ack);
    check("cfg_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) begin
      write_byte(wdata[i], 1'b0, ack);
      check($sformatf("cfg_data_ack_%0d", i), 32'(ack), 32'd1);
    end
    check("cfg_no_pulse_before_stop", 32'(pulse_cnt - base), 32'd0);
    i2c_stop();
    check("cfg_regs", cfg_regs, 32'h00050040);
    check("cfg_one_pulse", 32'(pulse_cnt - base), 32'd1);

    // Fifth byte is ACKed and dropped.
    base = pulse_cnt;
    i2c_start();
    write_byte({ADDR, 1'b0}, 1'b0, ack);
    for (int i = 0; i < 4; i++) write_byte(8'(8'h11 * (i + 1)), 1'b0, ack);
    write_byte(8'h55, 1'b0, ack);
    check("fifth_byte_ack", 32'(ack), 32'd1);
    check("fifth_byte_dropped", cfg_regs, 32'h11223344);
    i2c_stop();
    check("cfg_regs_after_5", cfg_regs, 32'h11223344);
    check("cfg_one_pulse_5", 32'(pulse_cnt - base), 32'd1);

    // Strobes mid-read stay pending; next read sees the last one, frm 3 -> 0.
    push10(vecs[2].exp);
    read_txn(10, 2);
    push10({8'h13, 8'h24, 8'h9A, 8'hC0, 8'h56, 8'h1B, 8'hDE, 8'h11, 8'h22, 8'h33});
    read_txn(10, -1);

    // Early NACK on the third byte, then repeated START read from p0.
    i2c_start();
    write_byte({ADDR, 1'b1}, 1'b0, ack);
    check("nack_addr_ack", 32'(ack), 32'd1);
    exp_q.push_back(8'h13); exp_q.push_back(8'h24); exp_q.push_back(8'h9A);
    for (int k = 0; k < 3; k++) begin
      read_byte(b, k != 2);
      check($sformatf("nack_read_%0d", k), 32'(b), 32'(exp_q.pop_front()));
    end
    check("nack_sda_released", 32'(sda_oe), 32'd0);
    exp_q.push_back(8'h13);
    read_txn(1, -1);

    // Short SCL pulse during a bit's low phase must not shift a bit.
    base = pulse_cnt;
    i2c_start();
    write_byte({ADDR, 1'b0}, 1'b0, ack);
    write_byte(8'hA5, 1'b1, ack);
    check("glitch_byte_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("glitch_cfg_regs", cfg_regs, 32'hA5223344);
    check("glitch_one_pulse", 32'(pulse_cnt - base), 32'd1);

    // Reset while driving a data bit releases SDA immediately.
    i2c_start();
    write_byte({ADDR, 1'b1}, 1'b0, ack);
    recv_bit(bit_v);
    check("pre_reset_bit7", 32'(bit_v), 32'd0);
    check("pre_reset_sda_oe", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_releases_sda", 32'(sda_oe), 32'd0);
    check("reset_clears_busy", 32'(busy), 32'd0);
    cyc(2);
    reset = 1'b0;
    m_sda_low = 1'b0;
    m_scl = 1'b1;
    cyc(2 * Q);
    check("post_reset_cfg_regs", cfg_regs, 32'd0);
    push10({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h11, 8'h22, 8'h33});
    read_txn(10, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
